// File: rtl/seq_abc_tracker.sv
// seq_abc_tracker: synthesizable monitor for the pattern a ##1 b ##[1:MAX_GAP] c.
// Tracks one attempt at a time and emits registered match/fail/abort pulses,
// a sticky fail cause and saturating match/fail counters.
module seq_abc_tracker #(
    parameter int MAX_GAP = 3,  // 1..15: b ##[1:MAX_GAP] c
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             e,
    output logic             match,
    output logic             fail,
    output logic [1:0]       fail_cause,
    output logic             abort,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_A  = 2'd1,
        WAIT_C = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NO_B    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [3:0] GAP_LIMIT     = 4'(MAX_GAP);

    state_t           state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic             match_q, match_d;
    logic             fail_q, fail_d;
    logic             abort_q, abort_d;
    logic [1:0]       fail_cause_q, fail_cause_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    // Next-state, pulse and counter computation; priority is en=0 > abort > normal.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        gap_d        = gap_q;
        match_d      = 1'b0;
        fail_d       = 1'b0;
        abort_d      = 1'b0;
        fail_cause_d = fail_cause_q;
        match_cnt_d  = match_cnt_q;
        fail_cnt_d   = fail_cnt_q;

        if (!en) begin
            // Frozen: state, gap and counters hold, pulses stay low.
        end else if (e && (state_q != IDLE)) begin
            state_d = IDLE;
            gap_d   = 4'd0;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (a) state_d = GOT_A;
                end
                GOT_A: begin
                    if (b) begin
                        state_d = WAIT_C;
                        gap_d   = 4'd1;
                    end else begin
                        fail_d       = 1'b1;
                        fail_cause_d = CAUSE_NO_B;
                        state_d      = a ? GOT_A : IDLE;
                    end
                end
                WAIT_C: begin
                    // c on the last allowed cycle still counts as a match.
                    if (c) begin
                        match_d = 1'b1;
                        gap_d   = 4'd0;
                        state_d = a ? GOT_A : IDLE;
                    end else if (gap_q == GAP_LIMIT) begin
                        fail_d       = 1'b1;
                        fail_cause_d = CAUSE_TIMEOUT;
                        gap_d        = 4'd0;
                        state_d      = a ? GOT_A : IDLE;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gap_d   = 4'd0;
                end
            endcase
        end

        if (match_d && (match_cnt_q != {CNT_W{1'b1}})) match_cnt_d = match_cnt_q + 1'b1;
        if (fail_d && (fail_cnt_q != {CNT_W{1'b1}}))   fail_cnt_d  = fail_cnt_q + 1'b1;
    end

    // State, gap, pulse and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= 4'd0;
            match_q      <= 1'b0;
            fail_q       <= 1'b0;
            abort_q      <= 1'b0;
            fail_cause_q <= 2'b00;
            match_cnt_q  <= '0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            match_q      <= match_d;
            fail_q       <= fail_d;
            abort_q      <= abort_d;
            fail_cause_q <= fail_cause_d;
            match_cnt_q  <= match_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign match      = match_q;
    assign fail       = fail_q;
    assign abort      = abort_q;
    assign fail_cause = fail_cause_q;
    assign match_cnt  = match_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seq_abc_tracker.sv
// Directed bench for seq_abc_tracker. A default instance (CNT_W=8) and a
// narrow instance (CNT_W=2) share stimulus; the narrow one shows saturation.
module tb_seq_abc_tracker;

    logic clk = 1'b0;
    logic rst, en, a, b, c, e;

    logic       match, fail, abort, busy;
    logic [1:0] fail_cause;
    logic [7:0] match_cnt, fail_cnt;

    logic       s_match, s_fail, s_abort, s_busy;
    logic [1:0] s_fail_cause;
    logic [1:0] s_match_cnt, s_fail_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_abc_tracker #(.MAX_GAP(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .e(e),
        .match(match), .fail(fail), .fail_cause(fail_cause), .abort(abort),
        .match_cnt(match_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );

    seq_abc_tracker #(.MAX_GAP(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .e(e),
        .match(s_match), .fail(s_fail), .fail_cause(s_fail_cause), .abort(s_abort),
        .match_cnt(s_match_cnt), .fail_cnt(s_fail_cnt), .busy(s_busy)
    );

    // Apply one input vector across one rising edge, then settle 1 time unit.
    task automatic drive(input logic ia, input logic ib, input logic ic,
                         input logic ie, input logic ien);
        a = ia; b = ib; c = ic; e = ie; en = ien;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Dirty the state first so reset has something to clear.
        rst = 1'b0;
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        do_reset();
        n_checks++; if ({match, fail, abort, busy} !== 4'b0000) begin n_errors++; $display("FAIL reset_pulses: got %b exp 0000", {match, fail, abort, busy}); end
        n_checks++; if (fail_cause !== 2'b00) begin n_errors++; $display("FAIL reset_cause: got %b exp 00", fail_cause); end
        n_checks++; if ({match_cnt, fail_cnt} !== 16'h0000) begin n_errors++; $display("FAIL reset_counts: got %h exp 0000", {match_cnt, fail_cnt}); end
    endtask

    task automatic test_clean();
        do_reset();
        drive(1, 0, 0, 0, 1);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL clean_busy_after_a: got %b exp 1", busy); end
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        n_checks++; if (match !== 1'b1) begin n_errors++; $display("FAIL clean_match: got %b exp 1", match); end
        n_checks++; if ({match_cnt, fail_cnt} !== {8'd1, 8'd0}) begin n_errors++; $display("FAIL clean_counts: got %0d/%0d exp 1/0", match_cnt, fail_cnt); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if ({match, busy} !== 2'b00) begin n_errors++; $display("FAIL clean_after: match/busy got %b exp 00", {match, busy}); end
    endtask

    task automatic test_gap_limit();
        do_reset();
        // c on the third cycle after b: gap==MAX_GAP and c together -> match.
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        n_checks++; if ({match, fail} !== 2'b10) begin n_errors++; $display("FAIL gap_edge_match: match/fail got %b exp 10", {match, fail}); end
        // Second attempt with no c: timeout after the third empty cycle.
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL gap_early_fail: got %b exp 0", fail); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if ({fail, fail_cause, busy} !== 4'b1100) begin n_errors++; $display("FAIL gap_timeout: fail/cause/busy got %b exp 1100", {fail, fail_cause, busy}); end
        n_checks++; if ({match_cnt, fail_cnt} !== {8'd1, 8'd1}) begin n_errors++; $display("FAIL gap_counts: got %0d/%0d exp 1/1", match_cnt, fail_cnt); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if ({fail, fail_cause} !== 3'b010) begin n_errors++; $display("FAIL gap_cause_hold: fail/cause got %b exp 010", {fail, fail_cause}); end
    endtask

    task automatic test_missing_b();
        do_reset();
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        n_checks++; if ({fail, fail_cause, busy} !== 4'b1011) begin n_errors++; $display("FAIL nob_fail: fail/cause/busy got %b exp 1011", {fail, fail_cause, busy}); end
        drive(0, 1, 0, 0, 1);
        n_checks++; if ({fail, busy} !== 2'b01) begin n_errors++; $display("FAIL nob_restart: fail/busy got %b exp 01", {fail, busy}); end
        drive(0, 0, 1, 0, 1);
        n_checks++; if ({match, fail_cause} !== 3'b101) begin n_errors++; $display("FAIL nob_match: match/cause got %b exp 101", {match, fail_cause}); end
        n_checks++; if ({match_cnt, fail_cnt} !== {8'd1, 8'd1}) begin n_errors++; $display("FAIL nob_counts: got %0d/%0d exp 1/1", match_cnt, fail_cnt); end
    endtask

    task automatic test_abort_enable();
        do_reset();
        drive(0, 0, 0, 1, 1);
        n_checks++; if ({abort, busy} !== 2'b00) begin n_errors++; $display("FAIL abort_idle: abort/busy got %b exp 00", {abort, busy}); end
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 1);  // e beats c
        n_checks++; if ({abort, match, busy} !== 3'b100) begin n_errors++; $display("FAIL abort_pulse: abort/match/busy got %b exp 100", {abort, match, busy}); end
        n_checks++; if ({match_cnt, fail_cnt} !== 16'h0000) begin n_errors++; $display("FAIL abort_counts: got %0d/%0d exp 0/0", match_cnt, fail_cnt); end
        drive(0, 0, 0, 0, 1);
        n_checks++; if (abort !== 1'b0) begin n_errors++; $display("FAIL abort_width: got %b exp 0", abort); end
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0);  // c while disabled is ignored
        n_checks++; if ({match, busy} !== 2'b01) begin n_errors++; $display("FAIL en_ignore_c: match/busy got %b exp 01", {match, busy}); end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        n_checks++; if ({fail, busy} !== 2'b01) begin n_errors++; $display("FAIL en_frozen: fail/busy got %b exp 01", {fail, busy}); end
        drive(0, 0, 1, 0, 1);
        n_checks++; if ({match, match_cnt} !== {1'b1, 8'd1}) begin n_errors++; $display("FAIL en_resume_match: match/cnt got %b/%0d exp 1/1", match, match_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(1, 1, 0, 0, 1);  // a/b mid-wait ignored
        n_checks++; if ({fail, match, busy} !== 3'b001) begin n_errors++; $display("FAIL b2b_midwait: fail/match/busy got %b exp 001", {fail, match, busy}); end
        drive(1, 0, 1, 0, 1);  // match and restart in the same edge
        n_checks++; if ({match, busy} !== 2'b11) begin n_errors++; $display("FAIL b2b_restart: match/busy got %b exp 11", {match, busy}); end
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        n_checks++; if ({match, match_cnt, fail_cnt} !== {1'b1, 8'd2, 8'd0}) begin n_errors++; $display("FAIL b2b_second: match/mc/fc got %b/%0d/%0d exp 1/2/0", match, match_cnt, fail_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 1);
            drive(0, 1, 0, 0, 1);
            drive(0, 0, 1, 0, 1);
        end
        n_checks++; if (s_match_cnt !== 2'd3) begin n_errors++; $display("FAIL sat_narrow: got %0d exp 3", s_match_cnt); end
        n_checks++; if (match_cnt !== 8'd5) begin n_errors++; $display("FAIL sat_wide: got %0d exp 5", match_cnt); end
        n_checks++; if (s_match !== 1'b1) begin n_errors++; $display("FAIL sat_pulse: got %b exp 1", s_match); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1);
            drive(0, 1, 0, 0, 1);
            drive(0, 0, 1, 0, 1);
        end
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        n_checks++; if ({busy, match_cnt} !== {1'b1, 8'd2}) begin n_errors++; $display("FAIL mid_pre: busy/cnt got %b/%0d exp 1/2", busy, match_cnt); end
        rst = 1'b1;
        drive(0, 0, 1, 0, 1);  // reset beats c
        rst = 1'b0;
        n_checks++; if ({match, fail, abort, busy, fail_cause, match_cnt, fail_cnt} !== 22'd0) begin n_errors++; $display("FAIL mid_reset: m/f/a/b/cause/mc/fc got %b%b%b%b/%b/%0d/%0d exp all 0", match, fail, abort, busy, fail_cause, match_cnt, fail_cnt); end
        drive(0, 0, 1, 0, 1);
        n_checks++; if ({match, busy, match_cnt} !== 10'd0) begin n_errors++; $display("FAIL mid_lone_c: match/busy/cnt got %b/%b/%0d exp 0/0/0", match, busy, match_cnt); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0; e = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_clean();
        test_gap_limit();
        test_missing_b();
        test_abort_enable();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_abc_tracker.md
Name: seq_abc_tracker

Overview:
- Hardware sequence monitor that sits directly downstream of the a/b/c/d/e stimulus stage.
- Samples the same one-hot control lines and tracks the temporal pattern a ##1 b ##[1:MAX_GAP] c, one attempt at a time (non-overlapping).
- Emits registered match/fail pulses plus saturating counts. Used as a synthesizable cross-check of the SVA results and as a scoreboard source.

Parameters:
- MAX_GAP, 3, maximum cycles allowed from b to c (1..15); b ##[1:MAX_GAP] c.
- CNT_W, 8, width of match_cnt and fail_cnt.

Ports:
- clk  in  1  single clock; all sampling on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  tracker enable; 0 freezes state, counters and gap counter.
- a  in  1  sequence start event.
- b  in  1  second event; required exactly one cycle after a.
- c  in  1  closing event.
- e  in  1  abort; cancels an in-progress attempt without failure.
- match  out  1  one-cycle pulse: attempt completed.
- fail  out  1  one-cycle pulse: attempt violated.
- fail_cause  out  2  valid with fail: 01 = no b after a; 10 = c timeout.
- abort  out  1  one-cycle pulse: attempt cancelled by e.
- match_cnt  out  CNT_W  saturating count of match pulses.
- fail_cnt  out  CNT_W  saturating count of fail pulses.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge), synchronous, highest priority:
  - state=IDLE, gap=0.
  - match, fail, abort, busy = 0; fail_cause = 00.
  - match_cnt = 0, fail_cnt = 0.
- States: IDLE, GOT_A, WAIT_C. gap is a 4-bit counter used only in WAIT_C.
- Priority per edge: rst > en=0 > e abort > normal transitions.
- en=0: state, gap and counters hold; match/fail/abort forced 0 that cycle.
- Abort: e=1 while state != IDLE -> IDLE, abort=1, gap=0, no count change. e in IDLE has no effect.
- IDLE: a=1 -> GOT_A; otherwise stay. b and c ignored in IDLE.
- GOT_A:
  - b=1 -> WAIT_C, gap=1.
  - b=0 -> fail=1, fail_cause=01; next state is GOT_A if a=1 this cycle (restart), else IDLE.
- WAIT_C:
  - c=1 -> match=1; next state is GOT_A if a=1 this cycle, else IDLE.
  - c=0 and gap==MAX_GAP -> fail=1, fail_cause=10; next state is GOT_A if a=1 this cycle, else IDLE.
  - c=0 and gap<MAX_GAP -> gap+1, stay.
  - a or b asserted mid-wait (no c) is ignored; it does not restart the attempt.
- Outputs are registered. A pulse is visible the cycle after the deciding sample edge and lasts exactly one cycle.
- fail_cause holds its last value between fails and is 00 only after reset.
- Counters increment on the same edge their pulse is set and saturate at 2^CNT_W-1 (no wrap).
- busy reflects the registered state.
- Simultaneous c and timeout in the same cycle: match wins.
- Multiple inputs high at once: handled by the priority rules above; no one-hot check is performed.

Test Plan:
- Reset then clean sequence (MAX_GAP=3): a@1, b@2, c@3 -> match pulse one cycle after edge 3; match_cnt=1; fail_cnt=0; busy low after.
- Gap limit: a@1, b@2, c@5 -> match (gap 3 ok). Second attempt a@10, b@11, c never -> fail with fail_cause=10 after edge 14; fail_cnt=1.
- Missing b with back-to-back a: a@1, a@2 (b=0) -> fail cause 01 at edge 2, tracker restarts in GOT_A; b@3, c@4 -> match; counts match=1, fail=1.
- Abort and enable: a@1, b@2, e@3 -> abort pulse, no count change. Then a@5, b@6, en=0 for 5 cycles, en=1, c -> match (gap frozen while disabled).
- Saturation with CNT_W=2: 5 consecutive clean matches -> match_cnt sticks at 3.
- Reset mid-operation: rst at edge 3 while in WAIT_C with match_cnt=2 -> all outputs 0, state IDLE; a following c alone produces no match.
